// File: rtl/race_game_pkg.sv
// Shared types and width constants for the race game control logic.
package race_game_pkg;

    localparam int SCORE_W = 16;
    localparam int LIVES_W = 2;
    localparam int SPEED_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_CRASH     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge one-shot for a raw push-button.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_async,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    // Shift the raw button through the synchronizer and keep the previous synced level.
    always_comb begin
        sync1_d = btn_async;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchronizer and edge-detect history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // One pulse per rising edge of the synchronized level, so a held button fires once.
    assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/race_game_controller.sv
// Game-level sequencer: title -> play -> crash freeze -> game over, with lives,
// score, speed level and the internal_reset pulse back to the collision checker.
module race_game_controller
    import race_game_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int CRASH_FRAMES = 120,
    parameter int BLINK_PERIOD = 8,
    parameter int SCORE_DIV    = 30,
    parameter int SPEED_STEP   = 10,
    parameter int MAX_SPEED    = 7,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_btn,
    input  logic                frame_tick,
    input  logic                collision_detected,
    output logic                internal_reset,
    output logic                game_running,
    output logic                crash_blink,
    output logic                game_over,
    output logic [LIVES_W-1:0]  lives,
    output logic [SCORE_W-1:0]  score,
    output logic [SPEED_W-1:0]  speed_level,
    output logic [1:0]          state_o
);

    localparam int FDIV_W  = $clog2(SCORE_DIV + 2);
    localparam int STEP_W  = $clog2(SPEED_STEP + 2);
    localparam int CRASH_W = $clog2(CRASH_FRAMES + 2);
    localparam int BLINK_W = $clog2(BLINK_PERIOD + 2);
    localparam int GUARD_W = $clog2(GUARD_CYCLES + 2);

    localparam logic [FDIV_W-1:0]  FDIV_LAST  = FDIV_W'(SCORE_DIV - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(SPEED_STEP - 1);
    localparam logic [CRASH_W-1:0] CRASH_LAST = CRASH_W'(CRASH_FRAMES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);
    localparam logic [GUARD_W-1:0] GUARD_LD   = GUARD_W'(GUARD_CYCLES);
    localparam logic [LIVES_W-1:0] LIVES_LD   = LIVES_W'(LIVES_INIT);
    localparam logic [SPEED_W-1:0] SPEED_MAX  = SPEED_W'(MAX_SPEED);
    localparam logic [SCORE_W-1:0] SCORE_SAT  = {SCORE_W{1'b1}};

    state_t               state_q, state_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SPEED_W-1:0]   speed_q, speed_d;
    logic [FDIV_W-1:0]    frame_div_q, frame_div_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [CRASH_W-1:0]   crash_cnt_q, crash_cnt_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 crash_blink_q, crash_blink_d;
    logic [GUARD_W-1:0]   guard_q, guard_d;
    logic                 ireset_q, ireset_d;
    logic                 start_pulse;

    btn_sync_edge u_start_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_async (start_btn),
        .pulse     (start_pulse)
    );

    // Next-state, game counters and the internal_reset request.
    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        score_d       = score_q;
        speed_d       = speed_q;
        frame_div_d   = frame_div_q;
        step_d        = step_q;
        crash_cnt_d   = crash_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        crash_blink_d = crash_blink_q;
        ireset_d      = 1'b0;
        // The guard only starts counting once the reset pulse itself has gone by.
        guard_d       = (guard_q != '0 && !ireset_q) ? guard_q - 1'b1 : guard_q;

        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_d       = ST_PLAYING;
                    lives_d       = LIVES_LD;
                    score_d       = '0;
                    speed_d       = '0;
                    frame_div_d   = '0;
                    step_d        = '0;
                    crash_cnt_d   = '0;
                    blink_cnt_d   = '0;
                    crash_blink_d = 1'b0;
                    ireset_d      = 1'b1;
                    guard_d       = GUARD_LD;
                end
            end
            ST_PLAYING: begin
                if (collision_detected && guard_q == '0) begin
                    // Collision beats a coincident frame tick: no score for that frame.
                    state_d       = ST_CRASH;
                    lives_d       = lives_q - 1'b1;
                    crash_cnt_d   = '0;
                    blink_cnt_d   = '0;
                    crash_blink_d = 1'b1;
                end else if (frame_tick) begin
                    if (frame_div_q == FDIV_LAST) begin
                        frame_div_d = '0;
                        if (score_q != SCORE_SAT) begin
                            score_d = score_q + 1'b1;
                        end
                        if (step_q == STEP_LAST) begin
                            step_d = '0;
                            if (speed_q != SPEED_MAX) begin
                                speed_d = speed_q + 1'b1;
                            end
                        end else begin
                            step_d = step_q + 1'b1;
                        end
                    end else begin
                        frame_div_d = frame_div_q + 1'b1;
                    end
                end
            end
            ST_CRASH: begin
                if (frame_tick) begin
                    if (crash_cnt_q == CRASH_LAST) begin
                        crash_cnt_d   = '0;
                        crash_blink_d = 1'b0;
                        if (lives_q == '0) begin
                            state_d = ST_GAME_OVER;
                        end else begin
                            state_d  = ST_PLAYING;
                            ireset_d = 1'b1;
                            guard_d  = GUARD_LD;
                        end
                    end else begin
                        crash_cnt_d = crash_cnt_q + 1'b1;
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_cnt_d   = '0;
                            crash_blink_d = ~crash_blink_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_GAME_OVER: begin
                // Results stay on display; they are cleared at the next game start.
                if (start_pulse) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers; reset drops straight to IDLE without a reset pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            lives_q       <= '0;
            score_q       <= '0;
            speed_q       <= '0;
            frame_div_q   <= '0;
            step_q        <= '0;
            crash_cnt_q   <= '0;
            blink_cnt_q   <= '0;
            crash_blink_q <= 1'b0;
            guard_q       <= '0;
            ireset_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            speed_q       <= speed_d;
            frame_div_q   <= frame_div_d;
            step_q        <= step_d;
            crash_cnt_q   <= crash_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            crash_blink_q <= crash_blink_d;
            guard_q       <= guard_d;
            ireset_q      <= ireset_d;
        end
    end

    assign internal_reset = ireset_q;
    assign game_running   = (state_q == ST_PLAYING);
    assign game_over      = (state_q == ST_GAME_OVER);
    assign crash_blink    = crash_blink_q;
    assign lives          = lives_q;
    assign score          = score_q;
    assign speed_level    = speed_q;
    assign state_o        = state_q;

endmodule

// File: doc/race_game_controller.md
Name: race_game_controller

Overview:
- Game-level FSM on the consuming end of the collision interface. Takes `collision_detected` from the collision checker and drives back `internal_reset`, which clears the checker and the car position logic.
- Sequences title → play → crash freeze → game over.
- Tracks lives, score (frames survived) and speed level for the car movement and HUD/VGA blocks.
- Single clock domain. All frame timing comes from a one-cycle `frame_tick` supplied by the VGA timing block.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..3).
- CRASH_FRAMES, 120, frames the game stays frozen after a collision (≥2).
- BLINK_PERIOD, 8, frames per toggle of `crash_blink`.
- SCORE_DIV, 30, frames in PLAYING per score point.
- SPEED_STEP, 10, score points per speed level increment.
- MAX_SPEED, 7, saturation value of `speed_level`.
- GUARD_CYCLES, 2, clocks after an `internal_reset` pulse during which `collision_detected` is ignored.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start_btn  in  1  raw asynchronous start push-button, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- collision_detected  in  1  registered flag from the collision checker
- internal_reset  out  1  one-cycle pulse clearing the collision checker and car positions
- game_running  out  1  high only in PLAYING; enables car motion
- crash_blink  out  1  user-car blink enable during CRASH
- game_over  out  1  high in GAME_OVER
- lives  out  2  remaining lives
- score  out  16  points, saturating at 16'hFFFF
- speed_level  out  3  obstacle speed index, 0..MAX_SPEED
- state_o  out  2  current state: IDLE=0, PLAYING=1, CRASH=2, GAME_OVER=3

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, with `state_o` = 0.
  - Internal counters 0.
  - Synchronizer flops 0.
- start_btn handling:
  - Passes through a 2-flop synchronizer, then a rising-edge detector.
  - `start_pulse` occurs 3 clocks after the raw input rises (worst case).
  - A held button yields exactly one pulse.
- IDLE:
  - On `start_pulse`: lives ← LIVES_INIT, score ← 0, speed_level ← 0, frame/blink counters ← 0.
  - Same edge: `internal_reset` = 1 for one cycle; go to PLAYING.
- PLAYING:
  - `game_running` = 1.
  - Each `frame_tick` increments the frame divider. When it reaches SCORE_DIV−1, it wraps to 0 and score increments.
  - Every SPEED_STEP points, `speed_level` increments, saturating at MAX_SPEED.
  - `collision_detected` is sampled only when the guard counter is 0. On a valid collision: lives ← lives−1, go to CRASH, clear the crash and blink counters, crash_blink ← 1.
  - Collision and `frame_tick` in the same cycle: collision wins, no score increment.
  - `start_pulse` is ignored.
- CRASH:
  - `game_running` = 0; score is frozen.
  - Each `frame_tick` increments the crash counter. `crash_blink` toggles every BLINK_PERIOD ticks.
  - On the tick where the count reaches CRASH_FRAMES:
    - If lives == 0: go to GAME_OVER.
    - Otherwise: pulse `internal_reset`, load the guard counter with GUARD_CYCLES, go to PLAYING.
  - `crash_blink` ← 0 on exit.
  - `collision_detected` and `start_pulse` are ignored.
- GAME_OVER:
  - `game_over` = 1.
  - lives, score and speed_level hold their values for display.
  - `start_pulse` → IDLE (score etc. are cleared on the next game start, not here).
- internal_reset:
  - Registered, exactly one clock wide, and never asserted in two consecutive cycles.
  - The guard counter is also loaded on the IDLE→PLAYING pulse.
- Widths and limits:
  - Score increment saturates; there is no wrap at 16'hFFFF.
  - The speed step counter continues to run after speed saturation but has no effect.
- rst_n assertion mid-game forces IDLE immediately (asynchronous); no `internal_reset` pulse is generated.

Decomposition:
- Package `race_game_pkg`:
  - State encoding localparams (IDLE/PLAYING/CRASH/GAME_OVER).
  - Width constants: SCORE_W=16, LIVES_W=2, SPEED_W=3.
- Sub-module `btn_sync_edge`: 2-flop synchronizer plus rising-edge one-shot, async active-low reset. Reusable for future buttons.

Test Plan:
- Bench parameters: LIVES_INIT=2, CRASH_FRAMES=4, BLINK_PERIOD=2, SCORE_DIV=3, SPEED_STEP=2, MAX_SPEED=3, GUARD_CYCLES=2.
- Start: release rst_n, pulse start_btn high 10 clocks → exactly one `internal_reset` pulse; state_o goes 0→1; lives=2, score=0, game_running=1.
- Scoring: in PLAYING, 12 frame_ticks, no collision → score=4, speed_level=2. 12 more ticks → score=8, speed_level=3 (saturated).
- Crash/respawn: collision_detected=1 together with a frame_tick → state_o=2, lives=1, score unchanged. crash_blink=1,1,0,0 over ticks 0–3. On the 4th tick, one `internal_reset` pulse, return to PLAYING. collision_detected held high for 2 cycles after the pulse is ignored.
- Game over: second collision, then 4 frame_ticks → state_o=3, game_over=1, lives=0, no `internal_reset` pulse. Further collision and frame_ticks change nothing. start_btn → IDLE.
- Ignored inputs: start_btn pulses during PLAYING and CRASH → no state change, no `internal_reset`. collision_detected in IDLE → stays IDLE.
- Async reset mid-CRASH: drop rst_n between clock edges → all outputs 0 immediately; state_o=0 after release.
